// File: rtl/mdu_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: op encodings,
// FSM states and small op-decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    ZERO,
    FIX
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for the final sign corrections.
module mdu_negate #(
  parameter int unsigned W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? ({W{1'b0}} - a_i) : a_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and restoring divide, one bit per clock,
// producing HI/LO results with a one-cycle done pulse.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     mul_add;
  logic [WIDTH-1:0]     rem_trial, rem_sub;
  logic                 no_borrow;

  assign a_neg = op_is_signed(op) & src_a[WIDTH-1];
  assign b_neg = op_is_signed(op) & src_b[WIDTH-1];

  mdu_negate #(.W(WIDTH)) u_abs_a (
    .neg_i (a_neg),
    .a_i   (src_a),
    .y_o   (a_mag)
  );

  mdu_negate #(.W(WIDTH)) u_abs_b (
    .neg_i (b_neg),
    .a_i   (src_b),
    .y_o   (b_mag)
  );

  mdu_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg_i (sa_q ^ sb_q),
    .a_i   (acc_q),
    .y_o   (prod_fix)
  );

  mdu_negate #(.W(WIDTH)) u_fix_quo (
    .neg_i (sa_q ^ sb_q),
    .a_i   (acc_q[WIDTH-1:0]),
    .y_o   (quo_fix)
  );

  // Remainder follows the dividend sign.
  mdu_negate #(.W(WIDTH)) u_fix_rem (
    .neg_i (sa_q),
    .a_i   (acc_q[2*WIDTH-1:WIDTH]),
    .y_o   (rem_fix)
  );

  always_comb begin
    mul_add = acc_q[0] ? a_q : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    // Shifted remainder is {acc msb, rem_trial}; the msb set means it already exceeds the divisor.
    rem_trial = acc_q[2*WIDTH-2:WIDTH-1];
    no_borrow = acc_q[2*WIDTH-1] | (rem_trial >= b_q);
    rem_sub   = rem_trial - b_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a_mag;
          b_d     = b_mag;
          sa_d    = a_neg;
          sb_d    = b_neg;
          dz_d    = 1'b0;
          state_d = (op_is_div(op) && (src_b == '0)) ? ZERO : LOAD;
        end
      end
      LOAD: begin
        acc_d   = op_is_div(op_q) ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{1'b0}}, b_q};
        cnt_d   = CNT_W'(WIDTH);
        state_d = ITER;
      end
      ITER: begin
        if (op_is_div(op_q)) begin
          acc_d = {(no_borrow ? rem_sub : rem_trial), acc_q[WIDTH-2:0], no_borrow};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (op_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
